// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit with HI/LO result registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division, both on magnitudes.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [1:0]           op_r;
  logic [WIDTH-1:0]     ma, mb, a_raw;
  logic                 neg_q, neg_r;
  logic [2*WIDTH-1:0]   acc;

  logic                 sgn_in;
  logic [CW-1:0]        bit_idx;
  logic [WIDTH:0]       rem_sh, rem_sub;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign sgn_in  = ~op[0];
  assign bit_idx = LAST - cnt;

  // One iteration step: MSB-first on the latched magnitudes.
  always_comb begin
    mul_next = {acc[2*WIDTH-2:0], 1'b0} + {{WIDTH{1'b0}}, (mb[bit_idx] ? ma : {WIDTH{1'b0}})};
    rem_sh   = {acc[2*WIDTH-1:WIDTH], ma[bit_idx]};
    rem_sub  = rem_sh - {1'b0, mb};
    if (rem_sub[WIDTH])
      div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_next = {rem_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign correction; a zero divisor bypasses it and returns the raw dividend in HI.
  always_comb begin
    prod   = cond_neg2(acc, neg_q);
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (op_r[1]) begin
      if (mb == '0) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end else begin
        fix_hi = cond_neg(acc[2*WIDTH-1:WIDTH], neg_r);
        fix_lo = cond_neg(acc[WIDTH-1:0], neg_q);
      end
    end
  end

  // Control and architectural HI/LO
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op_r  <= op;
      ma    <= cond_neg(a, sgn_in & a[WIDTH-1]);
      mb    <= cond_neg(b, sgn_in & b[WIDTH-1]);
      a_raw <= a;
      neg_q <= sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= sgn_in & a[WIDTH-1];
      acc   <= '0;
    end else if (state == RUN) begin
      acc <= op_r[1] ? div_next : mul_next;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, corner cases, moves and reset.
module tb_muldiv_unit;

  logic        clk, rst, start, mthi, mtlo, busy, done;
  logic [1:0]  op;
  logic [31:0] a, b, wdata, hi, lo;

  int n_chk  = 0;
  int n_fail = 0;
  int e_now  = 0;
  logic [31:0] cur_hi, cur_lo;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e_now++;
  endtask

  task automatic goto(input int n);
    while (e_now < n) step();
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    step();
    e_now = 0;
    start = 1'b0;
    chk("busy_after_e0", busy, 1);
    chk("lo_hold_e0", lo, cur_lo);
  endtask

  task automatic finish_op(input string tag, input logic [31:0] eh, input logic [31:0] el);
    goto(32);
    chk({tag, "_busy_e32"}, busy, 1);
    chk({tag, "_done_e32"}, done, 0);
    chk({tag, "_hi_hold"}, hi, cur_hi);
    chk({tag, "_lo_hold"}, lo, cur_lo);
    step();
    chk({tag, "_busy_e33"}, busy, 0);
    chk({tag, "_done_e33"}, done, 1);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    cur_hi = eh;
    cur_lo = el;
    step();
    chk({tag, "_done_e34"}, done, 0);
    chk({tag, "_busy_e34"}, busy, 0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    start_op(o, x, y);
    finish_op(tag, eh, el);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    cur_hi = '0; cur_lo = '0;
    step(); step();
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk); rst = 1'b1;
    step();

    run_op("mult_neg", MULT, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("div_m7_2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_7_2", DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    run_op("div_7_m2", DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    run_op("divu_by0", DIVU, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF);
    run_op("div_by0_neg", DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // Inputs asserted during RUN must be ignored
    start_op(MULTU, 32'd3, 32'd5);
    goto(4);
    @(negedge clk);
    start = 1'b1; op = DIV; mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEADBEEF;
    a = 32'd100; b = 32'd7;
    step();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    a = 32'h0BADF00D; b = 32'h12345678;
    chk("ign_hi_e5", hi, cur_hi);
    chk("ign_busy_e5", busy, 1);
    finish_op("ign", 32'd0, 32'd15);
    step(); step();
    chk("ign_busy_after", busy, 0);
    chk("ign_lo_after", lo, 32'd15);

    // Moves in IDLE
    @(negedge clk); mthi = 1'b1; wdata = 32'hDEADBEEF;
    step();
    mthi = 1'b0;
    chk("mthi_hi", hi, 32'hDEADBEEF);
    chk("mthi_lo", lo, 32'd15);
    chk("mthi_busy", busy, 0);
    chk("mthi_done", done, 0);
    @(negedge clk); mtlo = 1'b1; wdata = 32'hCAFEF00D;
    step();
    mtlo = 1'b0;
    chk("mtlo_lo", lo, 32'hCAFEF00D);
    chk("mtlo_hi", hi, 32'hDEADBEEF);
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'h12345678;
    step();
    mthi = 1'b0; mtlo = 1'b0;
    chk("mtboth_hi", hi, 32'h12345678);
    chk("mtboth_lo", lo, 32'h12345678);
    cur_hi = 32'h12345678; cur_lo = 32'h12345678;

    // start wins over a simultaneous move
    mtlo = 1'b1; wdata = 32'hCAFEF00D;
    start_op(MULTU, 32'd2, 32'd2);
    mtlo = 1'b0;
    finish_op("start_mtlo", 32'd0, 32'd4);

    // Reset mid-operation discards the run
    start_op(MULT, 32'hFFFFFFF0, 32'd9);
    goto(9);
    @(negedge clk); rst = 1'b0;
    step();
    chk("mid_rst_hi", hi, 0);
    chk("mid_rst_lo", lo, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    cur_hi = '0; cur_lo = '0;
    @(negedge clk); rst = 1'b1;
    repeat (40) step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_lo", lo, 0);
    run_op("mult_6x7", MULT, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the single-cycle CPU, downstream of the general-purpose register file. It consumes the two register read ports (rs value on `a`, rt value on `b`), executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle sequence, and holds the 64-bit result in the HI/LO registers. The pipeline-less core stalls on `busy` and later reads `hi`/`lo` (MFHI/MFLO) for write-back through the register file write port. The unit also supports MTHI and MTLO.

## Interface
- `WIDTH`, 32, operand and HI/LO width; only 32 is required to be supported.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-low: `rst`=0 at a rising edge resets the unit.
- `start`  in  1  request to begin the operation given by `op`; sampled only when `busy`=0.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  32  rs operand: multiplicand or dividend.
- `b`  in  32  rt operand: multiplier or divisor.
- `mthi`  in  1  write `wdata` into HI.
- `mtlo`  in  1  write `wdata` into LO.
- `wdata`  in  32  MTHI/MTLO data.
- `hi`  out  32  HI register; holds the product upper half or the remainder.
- `lo`  out  32  LO register; holds the product lower half or the quotient.
- `busy`  out  1  operation in progress; the CPU stalls while it is high.
- `done`  out  1  one-cycle pulse when `hi`/`lo` take a new operation result.

## Operation
- The state machine has three states: IDLE, RUN, FIX.
- **IDLE, `start`=1:**
  - Latch `op`.
  - Latch the operand magnitudes: |a| and |b| for signed ops, raw values for unsigned ops.
  - Latch the result sign flags.
  - Clear the 64-bit accumulator and set the iteration counter to 0.
  - Go to RUN. `busy` becomes 1.
- **RUN:** perform one iteration per cycle for 32 cycles (counter 0..31). On the last iteration go to FIX.
  - Multiply: shift-add on 32-bit unsigned magnitudes.
  - Divide: restoring shift-subtract on 32-bit unsigned magnitudes.
- **FIX:** apply two's-complement sign correction, write `hi`/`lo`, pulse `done`, drop `busy`, return to IDLE.
  - MULT: negate the 64-bit product if exactly one of a, b is negative.
  - DIV: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
- **Divide by zero (DIV or DIVU with b=0):** same latency; result is `lo`=32'hFFFFFFFF, `hi`=a, unmodified.
- **Signed overflow 0x80000000 / 0xFFFFFFFF:** `lo`=32'h80000000, `hi`=0. This falls out of the magnitude arithmetic; no special case is needed.
- **MTHI/MTLO in IDLE:** `hi` or `lo` takes `wdata` at the next edge. Both may be asserted in the same cycle.
- **Simultaneous events:**
  - `start` together with `mthi`/`mtlo` in IDLE: `start` wins and the move is dropped.
  - `start`, `mthi` or `mtlo` while `busy`=1: ignored, no effect on the running operation.
- **Operand capture:** `a` and `b` are captured only at the start edge. Later changes to the inputs do not affect the result.
- **`hi`/`lo` stability:** they hold their previous values throughout RUN and change only in FIX, on MTHI/MTLO, or on reset.

## Timing
- **Reset:** `rst`=0 at any edge, including mid-operation, sets state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, counter=0. Any operation in progress is discarded.
- **Cycle reference:** E0 is the edge that samples `start`=1 in IDLE.
- **`busy`:** 1 from after E0 until E33, i.e. exactly 33 cycles.
- **Iterations:** edges E1..E32 perform the 32 iterations.
- **E33 (FIX):** `hi`/`lo` update, `busy`→0, `done`→1.
- **`done`:** high for exactly the one cycle after E33 and cleared at E34.
- **Back-to-back starts:** a new `start` is accepted at E33+1 at the earliest, because `busy` is 0 in that cycle.
- **MTHI/MTLO latency:** 1 edge. `busy` and `done` are unaffected.
- **Outputs:** all outputs are registered; there is no combinational path from any input to any output.

## Test plan
- **Signed and unsigned multiply:**
  - Reset, then MULT a=0xFFFFFFFE, b=0x00000003 → `busy` high for 33 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA, `done` pulses 1 cycle at E33.
  - MULTU a=b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **Divide, signed and unsigned:**
  - DIV a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU a=7, b=2 → `lo`=3, `hi`=1.
  - DIV a=7, b=0xFFFFFFFE → `lo`=0xFFFFFFFD, `hi`=1.
- **Divide corner cases:**
  - DIVU a=0x1234, b=0 → `lo`=0xFFFFFFFF, `hi`=0x00001234 at E33.
  - DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Ignored inputs during RUN:**
  - Start MULTU 3×5, then at E5 assert `start` with DIV, and `mthi`/`wdata`=0xDEADBEEF.
  - Also change `a`/`b` mid-run.
  - Required: result `hi`=0, `lo`=15 at E33, no second operation, `busy` stays 0 after E33.
- **Moves:**
  - In IDLE: `mthi` with `wdata`=0xDEADBEEF → `hi`=0xDEADBEEF next edge.
  - In IDLE: `mtlo` with `wdata`=0xCAFEF00D → `lo` updated next edge.
  - `start` (MULTU 2×2) together with `mtlo`: `lo`=4 at E33, never 0xCAFEF00D.
- **Reset mid-operation:**
  - Start MULT, drive `rst`=0 at E10 → `hi`=`lo`=0, `busy`=`done`=0 after that edge.
  - Release reset, run MULT 6×7 → `lo`=42, `hi`=0 with full 33-cycle latency.
